plic_lite_ctrl: RTL and testbench
=================================

# plic_lite_ctrl

Platform-level interrupt controller for UninaSoC, single hart, one context. It collects the 32 statically mapped platform interrupt lines: line 0 is reserved, lines 1-4 are GPIO In, TIM0, TIM1 and UART from the PBUS. It gates, prioritises and arbitrates those lines into the core's external interrupt (mcause 11), and exposes a claim/complete handshake over a simple register port. An AXI-Lite-to-register adapter is outside this block.

## Interface
Parameters:
- NUM_SOURCES, 32, interrupt lines, including reserved line 0.
- PRIO_W, 3, priority width; priority 0 means never interrupt.

Ports:
- clock_i  in  1  system clock; all logic in this single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- intr_src_i  in  NUM_SOURCES  level-sensitive interrupt lines, synchronous to clock_i; bit 0 is ignored.
- reg_req_i  in  1  register access strobe; always accepted.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  9  byte address; bits [1:0] are ignored.
- reg_wdata_i  in  32  write data.
- reg_rvalid_o  out  1  read/write response; one cycle after reg_req_i.
- reg_rdata_o  out  32  read data; valid with reg_rvalid_o; 0 for writes.
- irq_o  out  1  external interrupt request to the core.

## Operation
Register map (byte offsets):
- 0x000 + 4*i: priority[i], PRIO_W bits, RW. Priority[0] reads 0; writes to it are dropped.
- 0x080: pending, RO.
- 0x100: enable, RW. Bit 0 is hardwired 0.
- 0x104: threshold, PRIO_W bits, RW.
- 0x108: claim (read) / complete (write).
- Any other address reads 0; writes to it are dropped.

Gateway (per source i ≥ 1):
- Sets pending[i] when intr_src_i[i] = 1, pending[i] = 0 and in_service[i] = 0.
- While in_service[i] = 1, the source is masked and cannot re-pend.

Arbiter:
- Candidates are sources with pending & enable & priority > threshold.
- The winner is the highest priority; ties go to the lowest ID.
- best_id_q and best_prio_q are registered from next-state pending, enable, priority and threshold.
- irq_o = (best_id_q != 0).

Claim (read of 0x108):
- reg_rdata_o returns best_id_q as sampled in the request cycle; 0 if there is no candidate.
- If the ID is non-zero: pending[id] is cleared and in_service[id] is set in that same cycle.

Complete (write of 0x108):
- If wdata[4:0] names an in-service source: in_service is cleared.
- Completing ID 0 or a source not in service is a no-op.
- Complete is independent of the enable bit.

Simultaneous events:
- A claim and a new pending on another source in the same cycle: both take effect.
- A claim and a complete in the same cycle cannot occur (one access per cycle).
- A complete on a source whose line is still high: the source re-pends on the next cycle.

Configuration writes (enable, priority, threshold) take effect on arbitration in the same edge they are written. Disabling a source does not clear its pending bit.

## Timing
- Reset values: all registers 0, irq_o = 0, reg_rvalid_o = 0, reg_rdata_o = 0.
- Reset asserted mid-operation clears pending, in_service and configuration at the next edge.
- Source latency: intr_src_i sampled high at edge k (enabled, priority above threshold) → pending and irq_o both high after edge k. That is 1 cycle.
- Claim latency: reg_req_i on a claim at edge k → reg_rvalid_o and the ID after edge k, with irq_o already updated (deasserted if no other candidate).
- Complete latency: a complete at edge k allows the source to re-pend at edge k+1.
- Exactly one response per request. There is no backpressure and no outstanding-request limit beyond 1 per cycle.

## Structure
- Add to uninasoc_pkg:
  - PLIC_NUM_SOURCES = 32 and PLIC_PRIO_W = 3.
  - Register offsets: PLIC_PRIO_BASE, PLIC_PENDING_OFF, PLIC_ENABLE_OFF, PLIC_THRESHOLD_OFF, PLIC_CLAIM_OFF.
  - The existing PLIC_*_INTERRUPT line constants.
- Sub-module plic_gateway:
  - One instance per source, generated for 1..NUM_SOURCES-1.
  - Holds the pending and in_service flops.
  - Inputs: src, claim, complete.
- The arbiter is a combinational compare loop in the top level, feeding the best_id_q and best_prio_q registers.

## Test plan
- Reset, then read all registers → all 0 and irq_o = 0. A write of 7 to priority[0], then a read → 0.
- Set priority[4] = 3, enable = 0x10, threshold = 0; drive intr_src_i[4] = 1 → irq_o = 1 one cycle later. A claim read returns 4 and irq_o drops. The line is held high and a complete write of 4 is issued → pending[4] = 1 the next cycle and irq_o = 1.
- Sources 2 and 3 both pending and enabled:
  - With priority 2 and 2 → claim returns 2.
  - With priority 1 and 5 → claim returns 3.
  - Then threshold = 5 → irq_o = 0 and claim returns 0.
- Complete write of 9 while nothing is in service → no state change. A claim read with nothing pending returns 0 and changes nothing.
- Source 1 is claimed while source 2 rises in the same cycle → the claim returns 1, pending[2] = 1 and irq_o stays 1.
- reset_i asserted while source 3 is in service and source 1 is pending → pending, in_service and enable read 0 and irq_o = 0 after one edge.

Source files
------------

// File: rtl/uninasoc_pkg.sv
// uninasoc_pkg: shared SoC constants.
// Adds the PLIC sizing, register offsets and interrupt line map.
package uninasoc_pkg;

  localparam int PLIC_NUM_SOURCES = 32;
  localparam int PLIC_PRIO_W      = 3;

  localparam logic [8:0] PLIC_PRIO_BASE     = 9'h000;
  localparam logic [8:0] PLIC_PENDING_OFF   = 9'h080;
  localparam logic [8:0] PLIC_ENABLE_OFF    = 9'h100;
  localparam logic [8:0] PLIC_THRESHOLD_OFF = 9'h104;
  localparam logic [8:0] PLIC_CLAIM_OFF     = 9'h108;

  localparam int PLIC_RESERVED_INTERRUPT = 0;
  localparam int PLIC_GPIO_IN_INTERRUPT  = 1;
  localparam int PLIC_TIM0_INTERRUPT     = 2;
  localparam int PLIC_TIM1_INTERRUPT     = 3;
  localparam int PLIC_UART_INTERRUPT     = 4;

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source pending / in_service tracking.
// Ports: clock_i, reset_i, src, claim, complete -> pending, pending_d.
module plic_gateway (
  input  logic clock_i,
  input  logic reset_i,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic pending_d
);

  logic in_service;
  logic in_service_d;

  always_comb begin
    pending_d    = pending;
    in_service_d = in_service;
    if (claim) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else begin
      if (complete && in_service) begin
        in_service_d = 1'b0;
      end
      // in_service masks re-pend until the edge after complete
      if (src && !pending && !in_service) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      pending    <= pending_d;
      in_service <= in_service_d;
    end
  end

endmodule

// File: rtl/plic_lite_ctrl.sv
// plic_lite_ctrl: single-context PLIC with claim/complete register port.
// Ports: clock_i, reset_i, intr_src_i, reg_* access port, irq_o.
module plic_lite_ctrl
  import uninasoc_pkg::*;
#(
  parameter int NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int PRIO_W      = PLIC_PRIO_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_SOURCES-1:0] intr_src_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [8:0]             reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_rvalid_o,
  output logic [31:0]            reg_rdata_o,
  output logic                   irq_o
);

  localparam int ID_W = $clog2(NUM_SOURCES);

  logic [6:0] word;
  logic       rd_acc;
  logic       wr_acc;
  logic       prio_sel;
  logic       pend_sel;
  logic       en_sel;
  logic       thr_sel;
  logic       clm_sel;
  logic       claim_hit;
  logic       complete_hit;

  assign word     = reg_addr_i[8:2];
  assign rd_acc   = reg_req_i && !reg_we_i;
  assign wr_acc   = reg_req_i && reg_we_i;
  assign prio_sel = (word >= PLIC_PRIO_BASE[8:2]) &&
                    (word < PLIC_PRIO_BASE[8:2] + 7'(NUM_SOURCES));
  assign pend_sel = word == PLIC_PENDING_OFF[8:2];
  assign en_sel   = word == PLIC_ENABLE_OFF[8:2];
  assign thr_sel  = word == PLIC_THRESHOLD_OFF[8:2];
  assign clm_sel  = word == PLIC_CLAIM_OFF[8:2];

  assign claim_hit    = rd_acc && clm_sel;
  assign complete_hit = wr_acc && clm_sel;

  logic [PRIO_W-1:0]      prio_q [NUM_SOURCES];
  logic [PRIO_W-1:0]      prio_d [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] enable_q;
  logic [NUM_SOURCES-1:0] enable_d;
  logic [PRIO_W-1:0]      threshold_q;
  logic [PRIO_W-1:0]      threshold_d;
  logic [NUM_SOURCES-1:0] pending_q;
  logic [NUM_SOURCES-1:0] pending_d;
  logic [ID_W-1:0]        best_id_q;
  logic [ID_W-1:0]        best_id_d;
  logic [PRIO_W-1:0]      best_prio_q;
  logic [PRIO_W-1:0]      best_prio_d;
  logic [31:0]            rdata_d;
  logic [ID_W-1:0]        prio_idx;

  assign prio_idx = ID_W'(word - PLIC_PRIO_BASE[8:2]);

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      prio_d[i] = prio_q[i];
    end
    if (wr_acc) begin
      if (en_sel) begin
        enable_d = reg_wdata_i[NUM_SOURCES-1:0];
      end
      if (thr_sel) begin
        threshold_d = reg_wdata_i[PRIO_W-1:0];
      end
      for (int i = 1; i < NUM_SOURCES; i++) begin
        if (prio_sel && prio_idx == ID_W'(i)) begin
          prio_d[i] = reg_wdata_i[PRIO_W-1:0];
        end
      end
    end
    enable_d[0] = 1'b0;
    prio_d[0]   = '0;
  end

  assign pending_q[0] = 1'b0;
  assign pending_d[0] = 1'b0;

  for (genvar g = 1; g < NUM_SOURCES; g++) begin : g_gw
    plic_gateway u_gw (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .src       (intr_src_i[g]),
      .claim     (claim_hit && best_id_q == ID_W'(g)),
      .complete  (complete_hit &&
                  reg_wdata_i[ID_W-1:0] == ID_W'(g)),
      .pending   (pending_q[g]),
      .pending_d (pending_d[g])
    );
  end

  // Starting best_prio at threshold with a strict compare gives
  // both the threshold cut and lowest-ID tie-break.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = threshold_d;
    for (int i = 1; i < NUM_SOURCES; i++) begin
      if (pending_d[i] && enable_d[i] &&
          prio_d[i] > best_prio_d) begin
        best_id_d   = ID_W'(i);
        best_prio_d = prio_d[i];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      unique case (1'b1)
        prio_sel: rdata_d = 32'(prio_q[prio_idx]);
        pend_sel: rdata_d = 32'(pending_q);
        en_sel:   rdata_d = 32'(enable_q);
        thr_sel:  rdata_d = 32'(threshold_q);
        clm_sel:  rdata_d = 32'(best_id_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        prio_q[i] <= '0;
      end
      enable_q     <= '0;
      threshold_q  <= '0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        prio_q[i] <= prio_d[i];
      end
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      best_id_q    <= best_id_d;
      best_prio_q  <= best_prio_d;
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= rdata_d;
    end
  end

  assign irq_o = best_id_q != '0;

endmodule

// File: tb/tb_plic_lite_ctrl.sv
// tb_plic_lite_ctrl: directed bench for plic_lite_ctrl.
// Linear register-port sequence with hand-computed expectations.
module tb_plic_lite_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src;
  logic        req;
  logic        we;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  plic_lite_ctrl dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .intr_src_i   (src),
    .reg_req_i    (req),
    .reg_we_i     (we),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_rvalid_o (rvalid),
    .reg_rdata_o  (rdata),
    .irq_o        (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [8:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; wdata = '0;
    @(posedge clk); #1;
    d = rdata;
    chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
    req = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a,
                    input logic [31:0] v);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = v;
    @(posedge clk); #1;
    chk("wr_rvalid", {31'b0, rvalid}, 32'd1);
    chk("wr_rdata", rdata, 32'd0);
    req = 1'b0;
  endtask

  task automatic pulse(input int i);
    @(negedge clk);
    src[i] = 1'b1;
    @(posedge clk); #1;
    src[i] = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [8:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic irq_chk(input string tag,
                         input logic exp);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    rst = 1'b1; src = '0; req = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    irq_chk("rst_irq", 1'b0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd_chk("rst_prio", 9'(4 * i), 32'd0);
    end
    rd_chk("rst_pend", 9'h080, 32'd0);
    rd_chk("rst_en", 9'h100, 32'd0);
    rd_chk("rst_thr", 9'h104, 32'd0);
    rd_chk("rst_claim", 9'h108, 32'd0);
    wr(9'h000, 32'd7);
    rd_chk("prio0_ro", 9'h000, 32'd0);
    wr(9'h0C0, 32'd5);
    rd_chk("bad_addr", 9'h0C0, 32'd0);
    rd_chk("bad_addr2", 9'h10C, 32'd0);
    wr(9'h100, 32'hFFFF_FFFF);
    rd_chk("en_bit0", 9'h100, 32'hFFFF_FFFE);

    wr(9'h010, 32'd3);
    wr(9'h100, 32'h10);
    wr(9'h104, 32'd0);
    irq_chk("s4_idle", 1'b0);
    @(negedge clk);
    src[4] = 1'b1;
    @(posedge clk); #1;
    irq_chk("s4_lat", 1'b1);
    rd_chk("s4_pend", 9'h080, 32'h10);
    rd_chk("s4_claim", 9'h108, 32'd4);
    irq_chk("s4_claim_irq", 1'b0);
    rd_chk("s4_masked", 9'h080, 32'h0);
    wr(9'h108, 32'd4);
    irq_chk("s4_cmp_irq", 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    irq_chk("s4_repend_irq", 1'b1);
    rd_chk("s4_repend", 9'h080, 32'h10);
    src[4] = 1'b0;
    rd_chk("s4_claim2", 9'h108, 32'd4);
    wr(9'h108, 32'd4);

    wr(9'h008, 32'd2);
    wr(9'h00C, 32'd2);
    wr(9'h100, 32'h0C);
    @(negedge clk);
    src[2] = 1'b1; src[3] = 1'b1;
    @(posedge clk); #1;
    src[2] = 1'b0; src[3] = 1'b0;
    irq_chk("tie_irq", 1'b1);
    rd_chk("tie_pend", 9'h080, 32'h0C);
    rd_chk("tie_claim", 9'h108, 32'd2);
    irq_chk("tie_irq2", 1'b1);
    wr(9'h108, 32'd2);
    rd_chk("tie_claim3", 9'h108, 32'd3);
    irq_chk("tie_irq3", 1'b0);
    wr(9'h108, 32'd3);

    wr(9'h008, 32'd1);
    wr(9'h00C, 32'd5);
    @(negedge clk);
    src[2] = 1'b1; src[3] = 1'b1;
    @(posedge clk); #1;
    src[2] = 1'b0; src[3] = 1'b0;
    rd_chk("hi_claim", 9'h108, 32'd3);
    irq_chk("hi_irq", 1'b1);
    wr(9'h108, 32'd3);
    wr(9'h104, 32'd5);
    irq_chk("thr_irq", 1'b0);
    rd_chk("thr_claim", 9'h108, 32'd0);
    rd_chk("thr_pend", 9'h080, 32'h04);

    wr(9'h108, 32'd9);
    rd_chk("cmp9_pend", 9'h080, 32'h04);
    irq_chk("cmp9_irq", 1'b0);
    wr(9'h104, 32'd0);
    irq_chk("thr0_irq", 1'b1);
    rd_chk("thr0_claim", 9'h108, 32'd2);
    wr(9'h108, 32'd2);
    rd_chk("empty_claim", 9'h108, 32'd0);
    irq_chk("empty_irq", 1'b0);
    rd_chk("empty_pend", 9'h080, 32'h0);

    wr(9'h004, 32'd4);
    wr(9'h100, 32'h06);
    pulse(1);
    irq_chk("s1_irq", 1'b1);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 9'h108;
    src[2] = 1'b1;
    @(posedge clk); #1;
    chk("sim_claim", rdata, 32'd1);
    irq_chk("sim_irq", 1'b1);
    req = 1'b0;
    src[2] = 1'b0;
    rd_chk("sim_pend", 9'h080, 32'h04);
    rd_chk("sim_claim2", 9'h108, 32'd2);
    irq_chk("sim_irq2", 1'b0);
    wr(9'h108, 32'd1);
    wr(9'h108, 32'd2);

    wr(9'h00C, 32'd6);
    wr(9'h100, 32'h0A);
    pulse(3);
    rd_chk("r_claim3", 9'h108, 32'd3);
    pulse(1);
    irq_chk("r_irq", 1'b1);
    rd_chk("r_pend", 9'h080, 32'h02);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    irq_chk("mid_rst_irq", 1'b0);
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("mid_pend", 9'h080, 32'h0);
    rd_chk("mid_en", 9'h100, 32'h0);
    rd_chk("mid_prio3", 9'h00C, 32'h0);
    rd_chk("mid_thr", 9'h104, 32'h0);
    wr(9'h00C, 32'd1);
    wr(9'h100, 32'h08);
    pulse(3);
    irq_chk("mid_s3_irq", 1'b1);
    rd_chk("mid_s3_claim", 9'h108, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
